// File: rtl/uart_tx_buffered.sv
// UART transmitter fed by a small transmit FIFO; frame format (parity, stop bits,
// baud divisor) is captured per word at the moment it leaves the FIFO.
module uart_tx_buffered #(
    parameter int MAX_WIDTH  = 32,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int OVERSAMPLE = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [MAX_WIDTH-1:0]            baud_rate_i,
    input  logic [1:0]                      parity_mode_i,
    input  logic                            stop_bits_i,
    input  logic [DATA_WIDTH-1:0]           data_i,
    input  logic                            valid_i,
    output logic                            ready_o,
    output logic                            tx_data_o,
    output logic                            busy_o,
    output logic                            tx_done_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = $clog2(DATA_WIDTH);
    localparam int TW = $clog2(OVERSAMPLE);

    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_PEN  = TW'(OVERSAMPLE - 2);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q, count_d;
    logic                  ready_q;

    state_t                state_q;
    logic [MAX_WIDTH-1:0]  baud_q, baud_cnt_q;
    logic [TW-1:0]         tick_q;
    logic [BW-1:0]         bit_idx_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  parity_bit_q, par_en_q, stop2_q, stop_idx_q;
    logic                  tx_q, busy_q, done_q;

    logic                  push, pop, bit_end, pen_cycle, final_stop, frame_end;
    logic [MAX_WIDTH-1:0]  baud_eff;
    logic [DATA_WIDTH-1:0] head_word;

    assign baud_eff   = (baud_rate_i == '0) ? MAX_WIDTH'(1) : baud_rate_i;
    assign head_word  = mem_q[rd_ptr_q];
    assign push       = valid_i && ready_q;
    assign bit_end    = (baud_cnt_q == baud_q - MAX_WIDTH'(1)) && (tick_q == TICK_LAST);
    // Second-to-last cycle of a bit; lets tx_done_o be registered yet land on the last cycle.
    assign pen_cycle  = (baud_q == MAX_WIDTH'(1)) ? (tick_q == TICK_PEN)
                      : ((tick_q == TICK_LAST) && (baud_cnt_q == baud_q - MAX_WIDTH'(2)));
    assign final_stop = !stop2_q || stop_idx_q;
    assign frame_end  = (state_q == S_STOP) && final_stop && bit_end;
    assign pop        = (count_q != '0) && ((state_q == S_IDLE) || frame_end);
    assign count_d    = count_q + CW'(push) - CW'(pop);

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
            ready_q <= (count_d != FULL_CNT);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            baud_q       <= MAX_WIDTH'(1);
            baud_cnt_q   <= '0;
            tick_q       <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            parity_bit_q <= 1'b0;
            par_en_q     <= 1'b0;
            stop2_q      <= 1'b0;
            stop_idx_q   <= 1'b0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= (state_q == S_STOP) && final_stop && pen_cycle;

            if (bit_end || (state_q == S_IDLE)) begin
                baud_cnt_q <= '0;
                tick_q     <= '0;
            end else if (baud_cnt_q == baud_q - MAX_WIDTH'(1)) begin
                baud_cnt_q <= '0;
                tick_q     <= tick_q + TW'(1);
            end else begin
                baud_cnt_q <= baud_cnt_q + MAX_WIDTH'(1);
            end

            if (pop) begin
                // Pop from IDLE or at the end of the stop bit(s): start the next frame at once.
                state_q      <= S_START;
                tx_q         <= 1'b0;
                busy_q       <= 1'b1;
                shift_q      <= head_word;
                parity_bit_q <= (^head_word) ^ parity_mode_i[1];
                par_en_q     <= parity_mode_i[0] ^ parity_mode_i[1];
                stop2_q      <= stop_bits_i;
                baud_q       <= baud_eff;
                stop_idx_q   <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        tx_q   <= 1'b1;
                        busy_q <= 1'b0;
                    end
                    S_START: begin
                        if (bit_end) begin
                            state_q   <= S_DATA;
                            tx_q      <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                            bit_idx_q <= '0;
                        end
                    end
                    S_DATA: begin
                        if (bit_end) begin
                            if (bit_idx_q == LAST_BIT) begin
                                if (par_en_q) begin
                                    state_q <= S_PARITY;
                                    tx_q    <= parity_bit_q;
                                end else begin
                                    state_q    <= S_STOP;
                                    tx_q       <= 1'b1;
                                    stop_idx_q <= 1'b0;
                                end
                            end else begin
                                tx_q      <= shift_q[0];
                                shift_q   <= shift_q >> 1;
                                bit_idx_q <= bit_idx_q + BW'(1);
                            end
                        end
                    end
                    S_PARITY: begin
                        if (bit_end) begin
                            state_q    <= S_STOP;
                            tx_q       <= 1'b1;
                            stop_idx_q <= 1'b0;
                        end
                    end
                    S_STOP: begin
                        if (bit_end) begin
                            if (!final_stop) begin
                                stop_idx_q <= 1'b1;
                            end else begin
                                state_q <= S_IDLE;
                                tx_q    <= 1'b1;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        tx_q    <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ready_o      = ready_q;
    assign tx_data_o    = tx_q;
    assign busy_o       = busy_q;
    assign tx_done_o    = done_q;
    assign fifo_count_o = count_q;

endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Parametrised UART transmitter with an integrated transmit FIFO, and the next generation of the team's fixed-configuration UART transmitter. It adds these features:
- Configurable data width and FIFO depth.
- Run-time parity mode and stop-bit count.
- A valid/ready write interface, so software or DMA can queue several bytes without waiting for `tx_done_o`.

It sits between the bus/register front end and the serial pin, and pairs with the existing `uart_rx`.

## Interface
- `MAX_WIDTH`, 32: width of `baud_rate_i`.
- `DATA_WIDTH`, 8: data bits per frame; legal range 5..9.
- `FIFO_DEPTH`, 4: transmit FIFO entries; legal range 2..256, power of two.
- `OVERSAMPLE`, 16: baud ticks per bit.
- `clk_i` input 1: system clock; all logic on the rising edge.
- `rst_ni` input 1: synchronous, active-low reset.
- `baud_rate_i` input MAX_WIDTH: clock cycles per baud tick, B; 0 is treated as 1.
- `parity_mode_i` input 2: parity select; 00 none, 01 even, 10 odd, 11 none.
- `stop_bits_i` input 1: stop bits; 0 selects one stop bit, 1 selects two.
- `data_i` input DATA_WIDTH: word to queue.
- `valid_i` input 1: write request.
- `ready_o` output 1: FIFO can accept a word; equals !full.
- `tx_data_o` output 1: serial line; idles high.
- `busy_o` output 1: a frame is in progress.
- `tx_done_o` output 1: one-cycle pulse on the last cycle of each frame.
- `fifo_count_o` output $clog2(FIFO_DEPTH+1): occupied FIFO entries.

## Operation
**FIFO**
- A word is pushed when `valid_i && ready_o` at a clock edge.
- `ready_o` is a registered function of count only; it does not depend on a same-cycle pop.
- When the FIFO is full, `valid_i` is ignored and the word is dropped by the bench's choice; no overflow flag.

**Frame format**, in order:
- Start bit, 0.
- `DATA_WIDTH` data bits, LSB first.
- Optional parity bit: even = XOR of the data bits; odd = its inverse.
- One or two stop bits, 1.

**Per-frame latching:** `baud_rate_i`, `parity_mode_i` and `stop_bits_i` are latched when a word is popped. Changes mid-frame take effect on the next frame only.

**Bit timing:** every bit holds for exactly OVERSAMPLE×B cycles. This is a cycle counter to B and a tick counter to OVERSAMPLE; there is no fractional accumulation.

**States:** IDLE, START, DATA, PARITY, STOP.
- IDLE -> START when the FIFO is non-empty; the word is popped on that edge.
- START -> DATA after 1 bit time.
- DATA -> PARITY after `DATA_WIDTH` bits if parity is enabled, otherwise DATA -> STOP.
- PARITY -> STOP after 1 bit time.
- STOP ends after 1 or 2 bit times. On its final cycle `tx_done_o` = 1. On that edge:
  - if the FIFO is non-empty, pop and go to START, so frames run back-to-back with zero idle cycles;
  - otherwise go to IDLE.

**Simultaneous push and pop:** `fifo_count_o` is unchanged. Pushing into an empty FIFO while IDLE does not bypass the FIFO.

**Reset:** asserting `rst_ni` mid-frame aborts the frame. Reset state, visible the cycle after `rst_ni` is sampled low:
- `tx_data_o` = 1, `busy_o` = 0, `tx_done_o` = 0, `ready_o` = 1.
- `fifo_count_o` = 0, FIFO contents discarded, state IDLE.

## Timing
- All outputs are registered.
- Push accepted at edge t: `fifo_count_o` increments at t+1.
- If IDLE, the pop occurs at edge t+1. At t+2, `tx_data_o` = 0 and `busy_o` = 1.
- Frame length in cycles: (1 + `DATA_WIDTH` + P + S) × OVERSAMPLE × B, where P is 0 or 1 (parity) and S is 1 or 2 (stop bits).
- `busy_o` falls the cycle after the `tx_done_o` pulse only if the FIFO is empty; it stays high across back-to-back frames.
- `ready_o` rises the cycle after a pop from a full FIFO.

## Test plan
1. **Single frame, even parity.** B=2, parity 01, one stop bit, write 0xA5.
   - `tx_data_o` = 0 from acceptance+2 for 32 cycles.
   - Then bits 1,0,1,0,0,1,0,1, 32 cycles each.
   - Parity bit 0, stop bit 1.
   - `tx_done_o` pulses once, 352 cycles after the start bit begins.
2. **Odd parity, two stop bits.** B=1, parity 10, stop 1, write 0x00.
   - Parity bit = 1.
   - Line high for 32 cycles after parity; frame = 12×16 = 192 cycles.
3. **FIFO fill and back-to-back.** FIFO_DEPTH=4, B=1, parity none; write 0x11, 0x22, 0x33, 0x44, 0x55 on consecutive cycles while the first pops.
   - `ready_o` drops when count reaches 4.
   - Each word that is not accepted (`valid_i` while `ready_o` = 0) is dropped.
   - Frames are transmitted contiguously: the start bit follows the stop bit with no idle cycle.
   - `busy_o` stays high throughout.
   - Loop `tx_data_o` into `uart_rx` (matching config); the accepted words are received in order.
4. **Mid-frame config change.** Change `parity_mode_i` from 01 to 00 during the DATA bits of frame 1.
   - Frame 1 still carries a parity bit.
   - Frame 2 has none; its length is 10 bit times.
5. **Reset mid-frame.** Pull `rst_ni` low during DATA with 2 words queued.
   - Next cycle: `tx_data_o` = 1, `busy_o` = 0, `fifo_count_o` = 0, `ready_o` = 1.
   - After release, no frame starts until a new write.
6. **baud_rate_i = 0.** Behaves identically to B=1: 16-cycle bits.
